// File: rtl/eem16_truth_table_scanner.sv
// Stimulus/capture wrapper for the 3-input function block: steps x through all eight codes,
// samples z after a settle window per code and grades the captured truth table.
module eem16_truth_table_scanner #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [7:0]  EXPECTED      = 8'b0100_0110
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       z,
   output logic       x0,
   output logic       x1,
   output logic       x2,
   output logic       busy,
   output logic       done,
   output logic       table_valid,
   output logic [7:0] truth_table,
   output logic       match,
   output logic [3:0] mismatches
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] x_q, x_d;
   logic [7:0] tt_q, tt_d;
   logic       tv_q, tv_d;
   logic       match_q, match_d;
   logic [3:0] mism_q, mism_d;

   // Table as it will look after this SAMPLE cycle, so the grade is ready in DONE.
   logic [7:0] sample_tt;
   logic [7:0] diff;
   logic [3:0] diff_count;

   always_comb begin
      sample_tt        = tt_q;
      sample_tt[idx_q] = z;
      diff             = sample_tt ^ EXPECTED;
      diff_count       = '0;
      for (int i = 0; i < 8; i++) begin
         diff_count = diff_count + 4'(diff[i]);
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      tt_d    = tt_q;
      tv_d    = tv_q;
      match_d = match_q;
      mism_d  = mism_q;
      x_d     = '0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = '0;
               cnt_d   = '0;
               tt_d    = '0;
               tv_d    = 1'b0;
               match_d = 1'b0;
               mism_d  = '0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_SAMPLE: begin
            tt_d = sample_tt;
            if (idx_q == 3'd7) begin
               tv_d    = 1'b1;
               match_d = (sample_tt == EXPECTED);
               mism_d  = diff_count;
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 3'd1;
               cnt_d   = '0;
               state_d = S_SETTLE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // abort wins over every transition, including an accepted start.
      if (abort) begin
         state_d = S_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
         tt_d    = '0;
         tv_d    = 1'b0;
         match_d = 1'b0;
         mism_d  = '0;
      end

      if (state_d == S_SETTLE || state_d == S_SAMPLE) begin
         x_d = idx_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         x_q     <= '0;
         tt_q    <= '0;
         tv_q    <= 1'b0;
         match_q <= 1'b0;
         mism_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         tt_q    <= tt_d;
         tv_q    <= tv_d;
         match_q <= match_d;
         mism_q  <= mism_d;
      end
   end

   assign x0          = x_q[0];
   assign x1          = x_q[1];
   assign x2          = x_q[2];
   assign busy        = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
   assign done        = (state_q == S_DONE);
   assign table_valid = tv_q;
   assign truth_table = tt_q;
   assign match       = match_q;
   assign mismatches  = mism_q;

endmodule

// File: tb/tb_eem16_truth_table_scanner.sv
// Bench for the truth-table scanner: default instance plus a SETTLE_CYCLES=1 instance,
// with per-scan expectations queued at start and graded when done pulses.
module tb_eem16_truth_table_scanner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   int         z_mode = 0;   // 0: real function, 1: stuck at 1, 2: stuck at 0

   logic       z_a, x0_a, x1_a, x2_a, busy_a, done_a, tv_a, match_a;
   logic [7:0] tt_a;
   logic [3:0] mism_a;
   logic       z_b, x0_b, x1_b, x2_b, busy_b, done_b, tv_b, match_b;
   logic [7:0] tt_b;
   logic [3:0] mism_b;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0] tt;
      logic       m;
      logic [3:0] mm;
      int         cyc;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   // Function block under test: minterms 1, 2, 6 in sum-of-products form.
   function automatic logic fn(input logic a2, input logic a1, input logic a0);
      return (~a2 & ~a1 & a0) | (~a2 & a1 & ~a0) | (a2 & a1 & ~a0);
   endfunction

   assign z_a = (z_mode == 0) ? fn(x2_a, x1_a, x0_a) : (z_mode == 1);
   assign z_b = (z_mode == 0) ? fn(x2_b, x1_b, x0_b) : (z_mode == 1);

   eem16_truth_table_scanner dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .z(z_a),
      .x0(x0_a), .x1(x1_a), .x2(x2_a), .busy(busy_a), .done(done_a),
      .table_valid(tv_a), .truth_table(tt_a), .match(match_a), .mismatches(mism_a)
   );

   eem16_truth_table_scanner #(.SETTLE_CYCLES(1)) dut_fast (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .z(z_b),
      .x0(x0_b), .x1(x1_b), .x2(x2_b), .busy(busy_b), .done(done_b),
      .table_valid(tv_b), .truth_table(tt_b), .match(match_b), .mismatches(mism_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] tt, input logic m, input logic [3:0] mm, input int cyc);
      exp_t e;
      e.tt = tt; e.m = m; e.mm = mm; e.cyc = cyc;
      sb_q.push_back(e);
   endtask

   task automatic pop_compare(input string tag, input logic [7:0] tt, input logic m,
                              input logic [3:0] mm, input logic tv, input int cyc);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check_eq({tag, "_table"}, 32'(tt), 32'(e.tt));
         check_eq({tag, "_match"}, 32'(m), 32'(e.m));
         check_eq({tag, "_mism"}, 32'(mm), 32'(e.mm));
         check_eq({tag, "_valid"}, 32'(tv), 32'd1);
         check_eq({tag, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
         $display("scan %s: table=%02h match=%0d mism=%0d done@%0d", tag, tt, m, mm, cyc);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at the negedge of cycle base+1; follows the default instance until done.
   task automatic watch_scan(input string tag, input int base, input int stray);
      int dc = -1;
      for (int c = base + 1; c <= base + 200; c++) begin
         if (c > base + 1) @(negedge clk);
         if (done_a) begin
            dc = c;
            break;
         end
         if (c <= base + 40) begin
            check_eq({tag, "_busy"}, 32'(busy_a), 32'd1);
            check_eq({tag, "_x"}, 32'({x2_a, x1_a, x0_a}), 32'((c - base - 1) / 5));
         end
         if (c == stray) start = 1'b1;
         else if (c == stray + 1) start = 1'b0;
      end
      if (dc < 0) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      check_eq({tag, "_done_busy"}, 32'(busy_a), 32'd0);
      check_eq({tag, "_done_x"}, 32'({x2_a, x1_a, x0_a}), 32'd0);
      pop_compare(tag, tt_a, match_a, mism_a, tv_a, dc - base);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int ndone;
      int d1;
      // 1: reset then idle
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(busy_a), 32'd0);
      check_eq("rst_x", 32'({x2_a, x1_a, x0_a}), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("idle_x", 32'({x2_a, x1_a, x0_a}), 32'd0);
         check_eq("idle_busy", 32'(busy_a), 32'd0);
         check_eq("idle_done", 32'(done_a), 32'd0);
      end
      check_eq("idle_outs", 32'({tv_a, tt_a, match_a, mism_a}), 32'd0);

      // 2: golden scan, results held afterwards
      z_mode = 0;
      push_exp(8'h46, 1'b1, 4'd0, 41);
      pulse_start();
      watch_scan("golden", 0, -5);
      idle_cycles(6);
      check_eq("hold_valid", 32'(tv_a), 32'd1);
      check_eq("hold_table", 32'(tt_a), 32'h46);
      check_eq("hold_match", 32'(match_a), 32'd1);

      // 3: stuck-at faults
      idle_cycles(20);
      z_mode = 1;
      push_exp(8'hFF, 1'b0, 4'd5, 41);
      pulse_start();
      watch_scan("stuck1", 0, -5);
      idle_cycles(20);
      z_mode = 2;
      push_exp(8'h00, 1'b0, 4'd3, 41);
      pulse_start();
      watch_scan("stuck0", 0, -5);
      z_mode = 0;

      // 4: abort at cycle 17, then a clean scan
      idle_cycles(20);
      pulse_start();
      for (int c = 1; c < 17; c++) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_eq("abort_busy", 32'(busy_a), 32'd0);
      check_eq("abort_x", 32'({x2_a, x1_a, x0_a}), 32'd0);
      check_eq("abort_valid", 32'(tv_a), 32'd0);
      check_eq("abort_table", 32'(tt_a), 32'd0);
      ndone = 0;
      for (int i = 0; i < 60; i++) begin
         if (done_a) ndone++;
         @(negedge clk);
      end
      check_eq("abort_no_done", 32'(ndone), 32'd0);
      push_exp(8'h46, 1'b1, 4'd0, 41);
      pulse_start();
      watch_scan("post_abort", 0, -5);

      // 5: stray start while busy, then start held high for back-to-back scans
      idle_cycles(20);
      push_exp(8'h46, 1'b1, 4'd0, 41);
      pulse_start();
      watch_scan("stray", 0, 10);
      start = 1'b1;
      push_exp(8'h46, 1'b1, 4'd0, 41);
      @(negedge clk);
      check_eq("b2b_idle_busy", 32'(busy_a), 32'd0);
      @(negedge clk);
      watch_scan("b2b", 42, -5);
      start = 1'b0;

      // 6: fast instance done at 17, async reset of both at cycle 25
      idle_cycles(40);
      push_exp(8'h46, 1'b1, 4'd0, 17);
      pulse_start();
      d1 = -1;
      for (int c = 1; c <= 25; c++) begin
         if (c > 1) @(negedge clk);
         if (done_b && d1 < 0) begin
            d1 = c;
            pop_compare("fast", tt_b, match_b, mism_b, tv_b, c);
         end
      end
      if (d1 < 0) check_eq("fast_timeout", 32'd0, 32'd1);
      check_eq("pre_reset_busy", 32'(busy_a), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("arst_busy", 32'(busy_a), 32'd0);
      check_eq("arst_x", 32'({x2_a, x1_a, x0_a}), 32'd0);
      check_eq("arst_outs", 32'({done_a, tv_a, tt_a, match_a, mism_a}), 32'd0);
      check_eq("arst_fast_valid", 32'({tv_b, tt_b}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycles(3);
      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
